// File: rtl/alarm_bank.sv
// Bank of independent alarm channels: persistence filter, latch-until-ack, event count, irq.
// Optional blinking indicator output enabled by defining ALARM_BLINK_EN.

module alarm_chan #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_i,
  input  logic             ack_i,
  input  logic [CNT_W-1:0] thr_i,     // effective threshold, never 0
  output logic             active_o,
  output logic             enter_o
);
  typedef enum logic [1:0] {S_IDLE, S_ARMING, S_ALARM, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the compare stays correct when the count is near full scale.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (in_i) begin
        if (thr_i == CNT_W'(1)) begin
          state_d = S_ALARM;
          cnt_d   = '0;
        end else begin
          state_d = S_ARMING;
          cnt_d   = CNT_W'(1);
        end
      end
      S_ARMING: begin
        if (!in_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= {1'b0, thr_i}) begin
          state_d = S_ALARM;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc[CNT_W-1:0];
        end
      end
      S_ALARM: if (ack_i) begin
        state_d = in_i ? S_HOLD : S_IDLE;
        cnt_d   = '0;
      end
      S_HOLD: if (!in_i) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active_o = (state_q == S_ALARM);
  assign enter_o  = (state_d == S_ALARM) && (state_q != S_ALARM);
endmodule

module alarm_bank #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 5,
  parameter int BLINK_LOG2 = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] in_i,
  input  logic [CNT_W-1:0]    threshold_i,
  input  logic [CHANNELS-1:0] ack_i,
  output logic [7:0]          out_o,
  output logic [CNT_W-1:0]    counter_o,
  output logic [CHANNELS-1:0] active_o,
  output logic                irq_o
);
  localparam logic [CNT_W+3:0] CNT_MAX = {4'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0]    eff_thr;
  logic [CHANNELS-1:0] enter;
  logic [3:0]          n_enter;
  logic [CNT_W+3:0]    cnt_sum;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic                irq_q;

  assign eff_thr = (threshold_i == '0) ? CNT_W'(1) : threshold_i;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    alarm_chan #(.CNT_W(CNT_W)) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .in_i     (in_i[g]),
      .ack_i    (ack_i[g]),
      .thr_i    (eff_thr),
      .active_o (active_o[g]),
      .enter_o  (enter[g])
    );
  end

  always_comb begin
    n_enter = '0;
    for (int i = 0; i < CHANNELS; i++) n_enter = n_enter + {3'b0, enter[i]};
  end

  // Simultaneous entries all count, but the total pins at full scale.
  assign cnt_sum   = {4'b0, counter_q} + {{CNT_W{1'b0}}, n_enter};
  assign counter_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      irq_q     <= |enter;
    end
  end

  assign counter_o = counter_q;
  assign irq_o     = irq_q;

`ifdef ALARM_BLINK_EN
  logic [BLINK_LOG2-1:0] presc_q;
  logic                  phase_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      phase_q <= 1'b1;
    end else begin
      presc_q <= presc_q + BLINK_LOG2'(1);
      if (presc_q == '1) phase_q <= ~phase_q;
    end
  end

  assign out_o = 8'(active_o & {CHANNELS{phase_q}});
`else
  assign out_o = 8'(active_o);
`endif
endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus randomized traffic
// compared every cycle against a streak/latch model of the channel rules.

module tb_alarm_bank;
  localparam int CH = 4;
  localparam int CW = 5;
  localparam int BL = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in_v, ack_v;
  logic [CW-1:0] thr;
  logic [7:0]    out_w;
  logic [CW-1:0] counter_w;
  logic [CH-1:0] active_w;
  logic          irq_w;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  alarm_bank #(.CHANNELS(CH), .CNT_W(CW), .BLINK_LOG2(BL)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_i        (in_v),
    .threshold_i (thr),
    .ack_i       (ack_v),
    .out_o       (out_w),
    .counter_o   (counter_w),
    .active_o    (active_w),
    .irq_o       (irq_w)
  );

  always #5 clk = ~clk;

  // Model: each channel tracks its run of high samples, a latched flag and a
  // suppressed flag; events are tallied as plain integers.
  int strk [CH];
  bit alm  [CH];
  bit hld  [CH];
  int m_cnt = 0;
  bit m_irq = 0;
  int n_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin strk[i] = 0; alm[i] = 0; hld[i] = 0; end
      m_cnt = 0; m_irq = 0; n_cyc = 0;
    end else begin
      int n, eff;
      n = 0;
      eff = (thr == 0) ? 1 : int'(thr);
      for (int i = 0; i < CH; i++) begin
        if (alm[i]) begin
          if (ack_v[i]) begin alm[i] = 0; hld[i] = in_v[i]; end
        end else if (hld[i]) begin
          if (!in_v[i]) hld[i] = 0;
        end else if (in_v[i]) begin
          strk[i]++;
          if (strk[i] >= eff) begin alm[i] = 1; strk[i] = 0; n++; end
        end else begin
          strk[i] = 0;
        end
      end
      m_irq = (n > 0);
      m_cnt = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
      n_cyc++;
    end
  end

  function automatic int m_active();
    int a = 0;
    for (int i = 0; i < CH; i++) if (alm[i]) a |= (1 << i);
    return a;
  endfunction

  function automatic int m_out();
`ifdef ALARM_BLINK_EN
    return (((n_cyc >> BL) & 1) == 0) ? m_active() : 0;
`else
    return m_active();
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("m.active",  int'(active_w),  m_active());
      chk("m.irq",     int'(irq_w),     int'(m_irq));
      chk("m.counter", int'(counter_w), m_cnt);
      chk("m.out",     int'(out_w),     m_out());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string nm, input int exp);
`ifndef ALARM_BLINK_EN
    chk(nm, int'(out_w), exp);
`endif
  endtask

  initial begin
    rst_n = 1'b1; in_v = '0; ack_v = '0; thr = CW'(5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.active",  int'(active_w),  0);
    chk("rst.counter", int'(counter_w), 0);
    chk("rst.irq",     int'(irq_w),     0);
    chk("rst.out",     int'(out_w),     0);
    run = 1;
    cyc(2);
    rst_n = 1'b1;

    // Four highs then low: no alarm.
    in_v = 4'b0001; cyc(4); in_v = '0; cyc(1);
    chk("t4.active", int'(active_w), 0);
    chk("t4.counter", int'(counter_w), 0);
    cyc(1);
    // Five highs: alarm on the fifth edge.
    in_v = 4'b0001; cyc(4);
    chk("t5.pre", int'(active_w), 0);
    cyc(1);
    chk("t5.active", int'(active_w), 1);
    chk("t5.irq", int'(irq_w), 1);
    chk("t5.counter", int'(counter_w), 1);
    chk_out("t5.out", 1);
    cyc(1);
    chk("t5.irq_off", int'(irq_w), 0);
    chk("t5.latched", int'(active_w), 1);
    in_v = '0; ack_v = 4'b0001; cyc(1); ack_v = '0;
    chk("t5.acked", int'(active_w), 0);

    // Ack while high -> hold, no re-arm until input drops.
    do_reset();
    in_v = 4'b0100; cyc(5);
    chk("h.active", int'(active_w), 4);
    chk("h.counter", int'(counter_w), 1);
    ack_v = 4'b0100; cyc(1); ack_v = '0;
    chk("h.hold", int'(active_w), 0);
    cyc(10);
    chk("h.noalarm", int'(active_w), 0);
    chk("h.cnt_same", int'(counter_w), 1);
    in_v = '0; cyc(1); in_v = 4'b0100; cyc(4);
    chk("h.rearm_pre", int'(active_w), 0);
    cyc(1);
    chk("h.realarm", int'(active_w), 4);
    chk("h.counter2", int'(counter_w), 2);
    chk_out("h.out", 4);

    // Threshold 0 behaves as 1; simultaneous entries give one pulse.
    do_reset();
    thr = '0; in_v = 4'b1111; cyc(1);
    chk("z.active", int'(active_w), 15);
    chk("z.irq", int'(irq_w), 1);
    chk("z.counter", int'(counter_w), 4);
    in_v = '0; cyc(1);
    chk("z.irq_once", int'(irq_w), 0);
    chk("z.latched", int'(active_w), 15);
    ack_v = 4'b1111; cyc(1); ack_v = '0;

    // Counter saturation.
    do_reset();
    thr = CW'(1);
    repeat (40) begin
      in_v = 4'b0001; ack_v = '0; cyc(1);
      in_v = '0; ack_v = 4'b0001; cyc(1);
    end
    ack_v = '0;
    chk("sat.counter", int'(counter_w), 31);

    // Reset mid-arming and during alarm discards the event.
    do_reset();
    thr = CW'(5); in_v = 4'b0001; cyc(3);
    rst_n = 1'b0; #1;
    chk("ra.active", int'(active_w), 0);
    chk("ra.counter", int'(counter_w), 0);
    in_v = '0; cyc(1); rst_n = 1'b1;
    in_v = 4'b0001; cyc(4);
    chk("ra.restart", int'(active_w), 0);
    cyc(1);
    chk("ra.alarm", int'(active_w), 1);
    rst_n = 1'b0; #1;
    chk("rl.active", int'(active_w), 0);
    chk("rl.counter", int'(counter_w), 0);
    chk("rl.irq", int'(irq_w), 0);
    chk("rl.out", int'(out_w), 0);
    in_v = '0; cyc(1); rst_n = 1'b1; cyc(2);
    chk("rl.after", int'(counter_w), 0);

    // Randomized traffic with live threshold changes and sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(99) < 20) in_v[i] = ~in_v[i];
        ack_v[i] = ($urandom_range(99) < 12);
      end
      if ($urandom_range(99) < 4) thr = CW'($urandom_range(7));
      if ($urandom_range(999) < 5) rst_n = 1'b0;
      else rst_n = 1'b1;
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent alarm channels (legal 1..8).
REQ-002 Parameter CNT_W, default 5, width of persistence counters, threshold and event counter.
REQ-003 Parameter BLINK_LOG2, default 3, blink half-period is 2^BLINK_LOG2 cycles (used only with ALARM_BLINK_EN).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in  input  CHANNELS  per-channel raw alarm condition, level-sensitive.
REQ-007 threshold  input  CNT_W  consecutive high samples needed to raise an alarm; 0 treated as 1.
REQ-008 ack  input  CHANNELS  per-channel acknowledge, level, sampled each edge.
REQ-009 out  output  8  registered channel indicator, bit i = channel i, bits >= CHANNELS held 0.
REQ-010 counter  output  CNT_W  registered saturating count of alarm events since reset.
REQ-011 active  output  CHANNELS  registered, bit i high while channel i is in ALARM.
REQ-012 irq  output  1  registered one-cycle pulse when any channel enters ALARM.

Function
REQ-013 Each channel SHALL run its own FSM with states IDLE, ARMING, ALARM, HOLD and a CNT_W-bit persistence count.
REQ-014 IDLE: in=1 -> ARMING with count 1, or -> ALARM directly if effective threshold is 1; in=0 -> stay.
REQ-015 ARMING: in=0 -> IDLE, count 0; in=1 and count+1 >= effective threshold -> ALARM; else count increments.
REQ-016 Net latency: with threshold T, active[i] SHALL rise on the edge that samples the T-th consecutive high in[i].
REQ-017 Threshold SHALL be compared live each cycle; lowering it below the current count raises ALARM on the next high sample.
REQ-018 ALARM: latched regardless of in until ack[i]=1; ack with in=1 -> HOLD, ack with in=0 -> IDLE.
REQ-019 HOLD: alarm suppressed, active[i]=0; in=0 -> IDLE; in=1 -> stay (no re-arming until in drops).
REQ-020 ack[i] SHALL be ignored in IDLE, ARMING and HOLD.
REQ-021 Persistence count SHALL clear to 0 on every entry to IDLE, ALARM and HOLD.
REQ-022 irq SHALL be high for exactly the cycle after the edge on which one or more channels entered ALARM; concurrent entries give one pulse.
REQ-023 counter SHALL add the number of channels entering ALARM on that edge (0..CHANNELS) and saturate at 2^CNT_W-1, never wrapping.
REQ-024 counter SHALL clear only on reset.

Reset
REQ-025 reset low SHALL immediately force all FSMs to IDLE and all counts, out, counter, active, irq and blink prescaler to 0.
REQ-026 Reset asserted mid-ARMING or mid-ALARM SHALL discard the event; after release channels restart from IDLE.
REQ-027 First state change after release SHALL occur on the first rising clk edge with reset high.

Configuration
REQ-028 Macro ALARM_BLINK_EN defined: free-running BLINK_LOG2-bit prescaler toggles a blink phase every 2^BLINK_LOG2 cycles; out[i] = active[i] AND phase, phase starts 1 after reset.
REQ-029 Macro ALARM_BLINK_EN undefined: no prescaler; out[i] = active[i] steadily.

Verification
REQ-030 CHANNELS=4, threshold=5, in[0] high 5 edges -> active=4'b0001 after edge 5, irq one cycle, counter=1; 4 edges then low -> no alarm, counter 0.
REQ-031 Alarm on ch2, in still high, ack[2] one cycle -> active[2]=0 (HOLD); 10 more high cycles -> no re-alarm; in low then high 5 edges -> alarm again, counter=2.
REQ-032 threshold=0, in=4'b1111 on one edge -> active=4'b1111 next, irq single pulse, counter=4.
REQ-033 CNT_W=5, 40 alarm/ack cycles on ch0 -> counter sticks at 31.
REQ-034 reset pulsed low mid-ARMING and during ALARM -> all outputs 0 immediately, no event counted.
REQ-035 With ALARM_BLINK_EN, BLINK_LOG2=3, ch1 alarmed -> out[1] alternates 8 cycles high, 8 low; without macro out=8'h02 steady.
